// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared types for the forwarding / hazard scheduler: mux select encodings, FSM states, stage tags.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fwd_hazard_ctrl_pkg;

    // Widest register address the tag pipe can carry; narrower addresses are zero-extended.
    localparam int RD_W = 8;

    // EX-stage operand mux select encodings.
    localparam logic [1:0] FW_REG   = 2'b00;  // ID/EX register data
    localparam logic [1:0] FW_WB    = 2'b01;  // WB result
    localparam logic [1:0] FW_EXMEM = 2'b10;  // EX/MEM result

    typedef enum logic [1:0] {
        ST_RUN        = 2'b00,
        ST_LOAD_STALL = 2'b01,
        ST_MEM_WAIT   = 2'b10
    } state_t;

    // Tag of the instruction in EX: loads must stay distinguishable for load-use detection.
    typedef struct packed {
        logic            valid;
        logic [RD_W-1:0] rd;
        logic            regwrite;
        logic            memread;
    } tag_t;

    // Tag of the instruction in MEM: only "will it write rd" matters there.
    typedef struct packed {
        logic            valid;
        logic [RD_W-1:0] rd;
    } wr_tag_t;

    function automatic wr_tag_t to_wr_tag(input tag_t t);
        wr_tag_t w;
        w.valid = t.valid & t.regwrite;
        w.rd    = t.rd;
        return w;
    endfunction

endpackage

// File: rtl/fwd_tag_match.sv
// Compares one ID source register against the EX and MEM tags; yields forward select and load hit.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is registered.
//   src      in  RD_W  source register (zero-extended)
//   use_src  in  1     instruction actually reads src
//   ex_tag   in  tag_t tag of instruction in EX
//   mem_tag  in  wr_tag_t tag of instruction in MEM
//   sel      out 2     FW_EXMEM / FW_WB / FW_REG
//   load_hit out 1     src is produced by a load currently in EX
module fwd_tag_match
    import fwd_hazard_ctrl_pkg::*;
(
    input  logic [RD_W-1:0] src,
    input  logic            use_src,
    input  tag_t            ex_tag,
    input  wr_tag_t         mem_tag,
    output logic [1:0]      sel,
    output logic            load_hit
);

    logic src_live;
    logic ex_match;
    logic mem_match;

    always_comb begin
        // r0 is hardwired zero, so it never takes a forwarded value.
        src_live  = use_src && (src != '0);
        ex_match  = src_live && ex_tag.valid && (ex_tag.rd == src);
        mem_match = src_live && mem_tag.valid && (mem_tag.rd == src);
        load_hit  = ex_match && ex_tag.memread;

        // The younger producer (EX) holds the newest value, so it wins ties.
        sel = FW_REG;
        if (ex_match && ex_tag.regwrite) begin
            sel = FW_EXMEM;
        end else if (mem_match) begin
            sel = FW_WB;
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// 5-stage pipeline forwarding select, load-use stall, branch flush and memory-wait freeze control.
// Latency: fwA_o/fwB_o registered (valid one cycle after ID, aligned with ID/EX); control outputs combinational.
// Backpressure: mem_req_i & !mem_ready_i freezes the whole pipeline; load-use holds PC and IF/ID one cycle.
//   clk_i, rst_i (async active-low); id_* describe the instruction in ID; branch_taken_i from ID;
//   mem_req_i/mem_ready_i from MEM; fwA_o/fwB_o EX mux selects; pc_write_o, ifid_write_o,
//   idex_bubble_o, flush_o, freeze_o pipeline controls; timeout_o sticky memory-wait overrun.
module fwd_hazard_ctrl
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int WAIT_LIMIT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_use_rs_i,
    input  logic              id_use_rt_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              branch_taken_i,
    input  logic              mem_req_i,
    input  logic              mem_ready_i,
    output logic [1:0]        fwA_o,
    output logic [1:0]        fwB_o,
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic              idex_bubble_o,
    output logic              flush_o,
    output logic              freeze_o,
    output logic              timeout_o
);

    localparam int               CNT_W     = $clog2(WAIT_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(WAIT_LIMIT);

    state_t           state_q, state_d;
    tag_t             ex_tag_q;
    wr_tag_t          mem_tag_q;
    tag_t             id_tag;
    logic [1:0]       fwa_q, fwb_q;
    logic [1:0]       sel_a, sel_b;
    logic             hit_a, hit_b;
    logic [CNT_W-1:0] wait_cnt_q;
    logic             timeout_q;
    logic             mem_stall;
    logic             load_stall;

    // WB tag is not kept: the register file writes in the first half-cycle,
    // so an instruction in WB is already visible to the ID read.

    fwd_tag_match u_match_a (
        .src      (RD_W'(id_rs_i)),
        .use_src  (id_use_rs_i),
        .ex_tag   (ex_tag_q),
        .mem_tag  (mem_tag_q),
        .sel      (sel_a),
        .load_hit (hit_a)
    );

    fwd_tag_match u_match_b (
        .src      (RD_W'(id_rt_i)),
        .use_src  (id_use_rt_i),
        .ex_tag   (ex_tag_q),
        .mem_tag  (mem_tag_q),
        .sel      (sel_b),
        .load_hit (hit_b)
    );

    always_comb begin
        state_d       = state_q;
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        idex_bubble_o = 1'b0;
        flush_o       = 1'b0;
        freeze_o      = 1'b0;

        // Once waiting, only mem_ready_i releases the freeze; that cycle advances normally.
        if (state_q == ST_MEM_WAIT) begin
            mem_stall = !mem_ready_i;
        end else begin
            mem_stall = mem_req_i && !mem_ready_i;
        end
        load_stall = !mem_stall && id_valid_i && (hit_a || hit_b);

        if (mem_stall) begin
            freeze_o     = 1'b1;
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
        end else if (load_stall) begin
            // Branch stays in ID and is re-evaluated once the stall clears.
            idex_bubble_o = 1'b1;
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
        end else begin
            flush_o = branch_taken_i;
        end

        case (state_q)
            ST_MEM_WAIT: begin
                if (mem_ready_i) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                if (mem_stall) begin
                    state_d = ST_MEM_WAIT;
                end else if (load_stall) begin
                    state_d = ST_LOAD_STALL;
                end else begin
                    state_d = ST_RUN;
                end
            end
        endcase

        id_tag.valid    = id_valid_i && !load_stall;
        id_tag.rd       = RD_W'(id_rd_i);
        id_tag.regwrite = id_regwrite_i;
        id_tag.memread  = id_memread_i;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= ST_RUN;
            ex_tag_q   <= '0;
            mem_tag_q  <= '0;
            fwa_q      <= FW_REG;
            fwb_q      <= FW_REG;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (!mem_stall) begin
                ex_tag_q   <= id_tag;
                mem_tag_q  <= to_wr_tag(ex_tag_q);
                // A bubble entering EX never consumes a forwarded operand.
                fwa_q      <= id_tag.valid ? sel_a : FW_REG;
                fwb_q      <= id_tag.valid ? sel_b : FW_REG;
                wait_cnt_q <= '0;
            end else if (wait_cnt_q != CNT_LIMIT) begin
                // Counter saturates at the limit; timeout stays set until reset.
                wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                if (wait_cnt_q == CNT_LIMIT - CNT_W'(1)) begin
                    timeout_q <= 1'b1;
                end
            end
        end
    end

    assign fwA_o     = fwa_q;
    assign fwB_o     = fwb_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
module tb_fwd_hazard_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       id_valid_i = 1'b0;
    logic [4:0] id_rs_i = '0;
    logic [4:0] id_rt_i = '0;
    logic       id_use_rs_i = 1'b0;
    logic       id_use_rt_i = 1'b0;
    logic [4:0] id_rd_i = '0;
    logic       id_regwrite_i = 1'b0;
    logic       id_memread_i = 1'b0;
    logic       branch_taken_i = 1'b0;
    logic       mem_req_i = 1'b0;
    logic       mem_ready_i = 1'b0;
    logic [1:0] fwA_o, fwB_o;
    logic       pc_write_o, ifid_write_o, idex_bubble_o, flush_o, freeze_o, timeout_o;

    logic [5:0] ctl;
    logic [3:0] fw;
    assign ctl = {pc_write_o, ifid_write_o, idex_bubble_o, flush_o, freeze_o, timeout_o};
    assign fw  = {fwA_o, fwB_o};

    int         checks = 0;
    int         errors = 0;
    logic [3:0] fw_q[$];
    logic [3:0] exp_fw;
    logic [5:0] exp_ctl;

    fwd_hazard_ctrl #(.REG_AW(5), .WAIT_LIMIT(4)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .id_valid_i     (id_valid_i),
        .id_rs_i        (id_rs_i),
        .id_rt_i        (id_rt_i),
        .id_use_rs_i    (id_use_rs_i),
        .id_use_rt_i    (id_use_rt_i),
        .id_rd_i        (id_rd_i),
        .id_regwrite_i  (id_regwrite_i),
        .id_memread_i   (id_memread_i),
        .branch_taken_i (branch_taken_i),
        .mem_req_i      (mem_req_i),
        .mem_ready_i    (mem_ready_i),
        .fwA_o          (fwA_o),
        .fwB_o          (fwB_o),
        .pc_write_o     (pc_write_o),
        .ifid_write_o   (ifid_write_o),
        .idex_bubble_o  (idex_bubble_o),
        .flush_o        (flush_o),
        .freeze_o       (freeze_o),
        .timeout_o      (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic adv();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_id(input int v, input int rs, input int rt, input int urs, input int urt,
                          input int rd, input int rw, input int mr);
        id_valid_i    = (v != 0);
        id_rs_i       = 5'(rs);
        id_rt_i       = 5'(rt);
        id_use_rs_i   = (urs != 0);
        id_use_rt_i   = (urt != 0);
        id_rd_i       = 5'(rd);
        id_regwrite_i = (rw != 0);
        id_memread_i  = (mr != 0);
    endtask

    task automatic do_reset();
        adv();
        rst_i = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        branch_taken_i = 1'b0;
        mem_req_i      = 1'b0;
        mem_ready_i    = 1'b0;
        fw_q.delete();
        adv();
        rst_i = 1'b1;
    endtask

    task automatic test_reset();
        #1 rst_i = 1'b0;
        #1;
        checks++; if (ctl !== 6'b110000) begin errors++; $display("FAIL reset ctl: got %b want %b", ctl, 6'b110000); end
        checks++; if (fw !== 4'b0000) begin errors++; $display("FAIL reset fw: got %b want %b", fw, 4'b0000); end
        adv();
        rst_i = 1'b1;
    endtask

    task automatic test_fwd_ex();
        do_reset();
        set_id(1, 0, 0, 0, 0, 3, 1, 0);            // add r3
        @(negedge clk_i); fw_q.push_back(4'b0000);
        adv(); exp_fw = fw_q.pop_front();
        checks++; if (fw !== exp_fw) begin errors++; $display("FAIL fwd_ex c0 fw: got %b want %b", fw, exp_fw); end
        set_id(1, 3, 4, 1, 1, 6, 1, 0);            // reads r3, r4
        @(negedge clk_i);
        checks++; if (ctl !== 6'b110000) begin errors++; $display("FAIL fwd_ex ctl: got %b want %b", ctl, 6'b110000); end
        fw_q.push_back(4'b1000);
        adv(); exp_fw = fw_q.pop_front();
        checks++; if (fw !== exp_fw) begin errors++; $display("FAIL fwd_ex c1 fw: got %b want %b", fw, exp_fw); end
    endtask

    task automatic test_ex_priority();
        do_reset();
        for (int c = 0; c < 2; c++) begin          // two writers of r3
            set_id(1, 0, 0, 0, 0, 3, 1, 0);
            @(negedge clk_i); fw_q.push_back(4'b0000);
            adv(); exp_fw = fw_q.pop_front();
            checks++; if (fw !== exp_fw) begin errors++; $display("FAIL prio writer%0d fw: got %b want %b", c, fw, exp_fw); end
        end
        set_id(1, 7, 3, 1, 1, 9, 1, 0);            // rt=r3 with r3 in EX and MEM
        @(negedge clk_i);
        checks++; if (ctl !== 6'b110000) begin errors++; $display("FAIL prio ctl: got %b want %b", ctl, 6'b110000); end
        fw_q.push_back(4'b0010);
        adv(); exp_fw = fw_q.pop_front();
        checks++; if (fw !== exp_fw) begin errors++; $display("FAIL prio ex_wins fw: got %b want %b", fw, exp_fw); end
        set_id(1, 3, 0, 1, 0, 10, 1, 0);           // r3 now only in MEM
        @(negedge clk_i); fw_q.push_back(4'b0100);
        adv(); exp_fw = fw_q.pop_front();
        checks++; if (fw !== exp_fw) begin errors++; $display("FAIL prio mem_fwd fw: got %b want %b", fw, exp_fw); end
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(1, 0, 0, 0, 0, 5, 1, 1);            // lw r5
        @(negedge clk_i); fw_q.push_back(4'b0000);
        adv(); exp_fw = fw_q.pop_front();
        checks++; if (fw !== exp_fw) begin errors++; $display("FAIL lu lw fw: got %b want %b", fw, exp_fw); end
        for (int c = 0; c < 2; c++) begin          // dependent on rs: stall once, then WB forward
            set_id(1, 5, 2, 1, 1, 6, 1, 0);
            @(negedge clk_i);
            exp_ctl = (c == 0) ? 6'b001000 : 6'b110000;
            checks++; if (ctl !== exp_ctl) begin errors++; $display("FAIL lu rs c%0d ctl: got %b want %b", c, ctl, exp_ctl); end
            fw_q.push_back((c == 0) ? 4'b0000 : 4'b0100);
            adv(); exp_fw = fw_q.pop_front();
            checks++; if (fw !== exp_fw) begin errors++; $display("FAIL lu rs c%0d fw: got %b want %b", c, fw, exp_fw); end
        end
        set_id(1, 0, 0, 0, 0, 7, 1, 1);            // lw r7
        @(negedge clk_i);
        checks++; if (ctl !== 6'b110000) begin errors++; $display("FAIL lu lw7 ctl: got %b want %b", ctl, 6'b110000); end
        fw_q.push_back(4'b0000);
        adv(); exp_fw = fw_q.pop_front();
        checks++; if (fw !== exp_fw) begin errors++; $display("FAIL lu lw7 fw: got %b want %b", fw, exp_fw); end
        for (int c = 0; c < 2; c++) begin          // dependent on rt only
            set_id(1, 1, 7, 0, 1, 8, 1, 0);
            @(negedge clk_i);
            exp_ctl = (c == 0) ? 6'b001000 : 6'b110000;
            checks++; if (ctl !== exp_ctl) begin errors++; $display("FAIL lu rt c%0d ctl: got %b want %b", c, ctl, exp_ctl); end
            fw_q.push_back((c == 0) ? 4'b0000 : 4'b0001);
            adv(); exp_fw = fw_q.pop_front();
            checks++; if (fw !== exp_fw) begin errors++; $display("FAIL lu rt c%0d fw: got %b want %b", c, fw, exp_fw); end
        end
    endtask

    task automatic test_r0();
        do_reset();
        set_id(1, 0, 0, 0, 0, 0, 1, 1);            // load "into" r0
        @(negedge clk_i); fw_q.push_back(4'b0000);
        adv(); exp_fw = fw_q.pop_front();
        checks++; if (fw !== exp_fw) begin errors++; $display("FAIL r0 c0 fw: got %b want %b", fw, exp_fw); end
        set_id(1, 0, 0, 1, 1, 4, 1, 0);            // reads r0 twice
        @(negedge clk_i);
        checks++; if (ctl !== 6'b110000) begin errors++; $display("FAIL r0 ctl: got %b want %b", ctl, 6'b110000); end
        fw_q.push_back(4'b0000);
        adv(); exp_fw = fw_q.pop_front();
        checks++; if (fw !== exp_fw) begin errors++; $display("FAIL r0 c1 fw: got %b want %b", fw, exp_fw); end
    endtask

    task automatic test_branch();
        do_reset();
        set_id(1, 1, 2, 1, 1, 0, 0, 0); branch_taken_i = 1'b1;
        @(negedge clk_i);
        checks++; if (ctl !== 6'b110100) begin errors++; $display("FAIL br flush ctl: got %b want %b", ctl, 6'b110100); end
        adv(); branch_taken_i = 1'b0;
        set_id(1, 0, 0, 0, 0, 5, 1, 1);            // lw r5
        adv();
        set_id(1, 5, 0, 1, 0, 0, 0, 0); branch_taken_i = 1'b1;
        @(negedge clk_i);
        checks++; if (ctl !== 6'b001000) begin errors++; $display("FAIL br during stall ctl: got %b want %b", ctl, 6'b001000); end
        adv();
        @(negedge clk_i);
        checks++; if (ctl !== 6'b110100) begin errors++; $display("FAIL br after stall ctl: got %b want %b", ctl, 6'b110100); end
        fw_q.push_back(4'b0100);
        adv(); exp_fw = fw_q.pop_front();
        checks++; if (fw !== exp_fw) begin errors++; $display("FAIL br after stall fw: got %b want %b", fw, exp_fw); end
        set_id(0, 0, 0, 0, 0, 0, 0, 0); mem_req_i = 1'b1; mem_ready_i = 1'b0;
        @(negedge clk_i);
        checks++; if (ctl !== 6'b000010) begin errors++; $display("FAIL br during freeze ctl: got %b want %b", ctl, 6'b000010); end
        fw_q.push_back(4'b0100);
        adv(); exp_fw = fw_q.pop_front();
        checks++; if (fw !== exp_fw) begin errors++; $display("FAIL br freeze hold fw: got %b want %b", fw, exp_fw); end
        branch_taken_i = 1'b0; mem_req_i = 1'b0; mem_ready_i = 1'b1;
        adv(); mem_ready_i = 1'b0;
    endtask

    task automatic test_mem_wait();
        do_reset();
        set_id(1, 0, 0, 0, 0, 3, 1, 0);
        @(negedge clk_i); fw_q.push_back(4'b0000);
        adv(); exp_fw = fw_q.pop_front();
        checks++; if (fw !== exp_fw) begin errors++; $display("FAIL mw c0 fw: got %b want %b", fw, exp_fw); end
        set_id(1, 3, 0, 1, 0, 6, 1, 0);
        @(negedge clk_i); fw_q.push_back(4'b1000);
        adv(); exp_fw = fw_q.pop_front();
        checks++; if (fw !== exp_fw) begin errors++; $display("FAIL mw c1 fw: got %b want %b", fw, exp_fw); end
        set_id(1, 3, 0, 1, 0, 8, 1, 0); mem_req_i = 1'b1; mem_ready_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            checks++; if (ctl !== 6'b000010) begin errors++; $display("FAIL mw freeze%0d ctl: got %b want %b", c, ctl, 6'b000010); end
            fw_q.push_back(4'b1000);
            adv(); exp_fw = fw_q.pop_front();
            checks++; if (fw !== exp_fw) begin errors++; $display("FAIL mw hold%0d fw: got %b want %b", c, fw, exp_fw); end
        end
        mem_ready_i = 1'b1;
        @(negedge clk_i);
        checks++; if (ctl !== 6'b110000) begin errors++; $display("FAIL mw ready ctl: got %b want %b", ctl, 6'b110000); end
        fw_q.push_back(4'b0100);
        adv(); exp_fw = fw_q.pop_front();
        checks++; if (fw !== exp_fw) begin errors++; $display("FAIL mw release fw: got %b want %b", fw, exp_fw); end
        mem_req_i = 1'b0; mem_ready_i = 1'b0;
        set_id(1, 3, 0, 1, 0, 11, 1, 0);           // r3 writer has retired to WB
        @(negedge clk_i); fw_q.push_back(4'b0000);
        adv(); exp_fw = fw_q.pop_front();
        checks++; if (fw !== exp_fw) begin errors++; $display("FAIL mw after fw: got %b want %b", fw, exp_fw); end
    endtask

    task automatic test_timeout_reset();
        do_reset();
        mem_req_i = 1'b1; mem_ready_i = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_i);
            exp_ctl = {5'b00001, (k >= 4)};
            checks++; if (ctl !== exp_ctl) begin errors++; $display("FAIL to wait%0d ctl: got %b want %b", k, ctl, exp_ctl); end
            adv();
        end
        mem_ready_i = 1'b1;
        @(negedge clk_i);
        checks++; if (ctl !== 6'b110001) begin errors++; $display("FAIL to sticky ctl: got %b want %b", ctl, 6'b110001); end
        adv(); mem_req_i = 1'b0; mem_ready_i = 1'b0;
        set_id(1, 0, 0, 0, 0, 3, 1, 0);
        adv();
        set_id(1, 3, 0, 1, 0, 6, 1, 0);
        adv();
        checks++; if (fw !== 4'b1000) begin errors++; $display("FAIL to pre_reset fw: got %b want %b", fw, 4'b1000); end
        #2 rst_i = 1'b0;
        #1;
        checks++; if (fw !== 4'b0000) begin errors++; $display("FAIL async reset fw: got %b want %b", fw, 4'b0000); end
        checks++; if (ctl !== 6'b110000) begin errors++; $display("FAIL async reset ctl: got %b want %b", ctl, 6'b110000); end
        adv();
        rst_i = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench still running at time %0t, limit 200000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fwd_ex();
        test_ex_priority();
        test_load_use();
        test_r0();
        test_branch();
        test_mem_wait();
        test_timeout_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
